yarp_mem_arbiter: RTL and testbench
===================================

YARP_MEM_ARBITER -- requirements
Module: yarp_mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum BUSY cycles without mem_ack_i before an error completion; legal range 1..255.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 instr_req_i  in  1  fetch request; held until instr_gnt_o.
REQ-005 instr_addr_i  in  32  fetch address; always a word read.
REQ-006 instr_gnt_o  out  1  fetch request accepted this cycle.
REQ-007 instr_rvalid_o  out  1  fetch completion pulse.
REQ-008 instr_rdata_o  out  32  fetch data; valid with instr_rvalid_o.
REQ-009 data_req_i  in  1  load/store request; held until data_gnt_o.
REQ-010 data_addr_i / data_byte_en_i / data_wr_i / data_wr_data_i  in  32/2/1/32  load/store address, size, write flag and write data.
REQ-011 data_gnt_o  out  1  load/store request accepted this cycle.
REQ-012 data_rvalid_o  out  1  load/store completion pulse; pulses for writes too.
REQ-013 data_rdata_o  out  32  raw load data; valid with data_rvalid_o.
REQ-014 err_o  out  1  completion is a timeout; valid with either rvalid.
REQ-015 mem_req_o / mem_addr_o / mem_byte_en_o / mem_wr_o / mem_wr_data_o  out  1/32/2/1/32  shared memory port.
REQ-016 mem_ack_i  in  1  memory completed the current transaction.
REQ-017 mem_rd_data_i  in  32  read data; valid with mem_ack_i.

Function
REQ-018 States: IDLE, BUSY; one transaction outstanding at most.
REQ-019 IDLE with exactly one request asserted: grant it; gnt_o is combinational, high for one cycle; latch its fields; next state BUSY.
REQ-020 IDLE with both requests asserted: grant the requester not recorded in last_owner; last_owner resets to INSTR, so the first contention goes to data.
REQ-021 A grant updates last_owner to the granted requester.
REQ-022 Fetch latch values: byte_en = Word encoding, wr = 0, wr_data = 0.
REQ-023 In BUSY, mem_req_o = 1 and all mem_* outputs come from the latched registers, stable until completion; in IDLE, mem_req_o = 0.
REQ-024 BUSY with mem_ack_i: on the next cycle, the owner's rvalid_o = 1 for one cycle, owner's rdata_o = mem_rd_data_i (0 for writes), err_o = 0; state returns to IDLE.
REQ-025 The cycle rvalid_o is high, state is IDLE and a new grant is allowed: back-to-back throughput is one transaction per 2 cycles plus memory latency.
REQ-026 Wait counter: 8 bits, cleared on grant, incremented each BUSY cycle without ack.
REQ-027 Timeout: counter reaches TIMEOUT_CYCLES without ack -> completion as REQ-024 with rdata_o = 0 and err_o = 1; mem_req_o drops.
REQ-028 Ack and timeout in the same cycle: ack wins, err_o = 0.
REQ-029 mem_ack_i in IDLE is ignored; it produces no rvalid.
REQ-030 The non-owner's rvalid_o, rdata_o and gnt_o stay 0 throughout a transaction.
REQ-031 Grant never occurs while in BUSY, even with the non-owner requesting.

Reset
REQ-032 On reset assertion, immediately: state = IDLE, last_owner = INSTR, counter = 0, every output = 0, regardless of clock.
REQ-033 Reset mid-transaction abandons it with no rvalid; first grant possible on the first clock edge after deassertion.

Structure
REQ-034 yarp_pkg holds arb_state_t {IDLE, BUSY} and mem_owner_t {INSTR, DATA}; the existing access-size encoding (Byte/Half/Word) is reused.
REQ-035 No sub-module; the arbitration pick is a few lines inline.

Verification
REQ-036 Single fetch: instr_req_i, addr 0x100, ack 3 cycles later with 0xDEADBEEF -> gnt in cycle 0; mem_req_o in cycles 1-3; instr_rvalid_o with 0xDEADBEEF in cycle 4; err_o = 0.
REQ-037 Contention after reset: both request in cycle 0 -> data granted first, instr granted in the first IDLE cycle after data rvalid; a repeat of both requests then grants data again.
REQ-038 Store: data_wr_i = 1, addr 0x2000, byte_en Half, data 0x1234 -> mem outputs match and stay stable; data_rvalid_o with rdata 0.
REQ-039 Timeout with TIMEOUT_CYCLES = 4: no ack -> data_rvalid_o = 1 and err_o = 1 with rdata 0; mem_req_o low afterwards.
REQ-040 Reset asserted mid-BUSY -> mem_req_o = 0 with no clock edge; no rvalid; a fresh request is granted after deassertion.
REQ-041 Ack in the same cycle the counter hits the limit -> normal completion, err_o = 0.

Source files
------------

// File: rtl/yarp_pkg.sv
// Shared types for the yarp memory subsystem: arbiter state, port owner, access size.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package yarp_pkg;

    // Access-size encoding carried on byte_en buses throughout the core.
    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } mem_access_size_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    typedef enum logic {
        INSTR = 1'b0,
        DATA  = 1'b1
    } mem_owner_t;

    localparam int unsigned WAIT_CNT_W = 8;

endpackage

// File: rtl/yarp_mem_arbiter.sv
// Two-port (fetch / load-store) arbiter onto a single memory port, one transaction in flight.
// Latency: grant is combinational in IDLE; completion (rvalid) one cycle after mem_ack_i or timeout.
// Backpressure: a requester holds req until gnt; no grant is issued while a transaction is in flight.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   instr_req/addr -> instr_gnt     fetch request side (always a word read)
//   instr_rvalid/rdata              fetch completion pulse and data
//   data_req/addr/byte_en/wr/wr_data -> data_gnt   load/store request side
//   data_rvalid/rdata               load/store completion pulse (also for stores) and data
//   err_o                           completion was a timeout; qualifies either rvalid
//   mem_*                           shared memory port; mem_ack_i/mem_rd_data_i return path
module yarp_mem_arbiter
    import yarp_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,

    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic [1:0]  data_byte_en_i,
    input  logic        data_wr_i,
    input  logic [31:0] data_wr_data_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,

    output logic        err_o,

    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic [1:0]  mem_byte_en_o,
    output logic        mem_wr_o,
    output logic [31:0] mem_wr_data_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rd_data_i
);

    // Counter value seen in the last BUSY cycle before the limit would be reached.
    localparam logic [WAIT_CNT_W-1:0] TMO_LAST = WAIT_CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t             state_q;
    arb_state_t             state_d;
    mem_owner_t             last_owner_q;
    mem_owner_t             owner_q;
    mem_owner_t             pick;
    logic                   grant;
    logic                   ack_done;
    logic                   tmo_done;
    logic [WAIT_CNT_W-1:0]  wait_cnt_q;

    // Arbitration pick. Gated by reset so gnt is low for the whole reset window,
    // not just after the first edge.
    always_comb begin
        grant = 1'b0;
        pick  = INSTR;
        if (state_q == IDLE && !reset) begin
            if (instr_req_i && data_req_i) begin
                grant = 1'b1;
                pick  = (last_owner_q == INSTR) ? DATA : INSTR;
            end else if (data_req_i) begin
                grant = 1'b1;
                pick  = DATA;
            end else if (instr_req_i) begin
                grant = 1'b1;
                pick  = INSTR;
            end
        end
    end

    // Ack has priority: timeout only fires in a BUSY cycle with no ack.
    assign ack_done = (state_q == BUSY) && mem_ack_i;
    assign tmo_done = (state_q == BUSY) && !mem_ack_i && (wait_cnt_q == TMO_LAST);

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = BUSY;
            BUSY:    if (ack_done || tmo_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: combinational outputs
    always_comb begin
        mem_req_o   = (state_q == BUSY);
        instr_gnt_o = grant && (pick == INSTR);
        data_gnt_o  = grant && (pick == DATA);
    end

    // Request latch, wait counter and registered completion outputs.
    // Completion outputs default low each cycle, so rvalid/rdata/err are single-cycle pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_owner_q   <= INSTR;
            owner_q        <= INSTR;
            wait_cnt_q     <= '0;
            mem_addr_o     <= '0;
            mem_byte_en_o  <= '0;
            mem_wr_o       <= 1'b0;
            mem_wr_data_o  <= '0;
            instr_rvalid_o <= 1'b0;
            instr_rdata_o  <= '0;
            data_rvalid_o  <= 1'b0;
            data_rdata_o   <= '0;
            err_o          <= 1'b0;
        end else begin
            instr_rvalid_o <= 1'b0;
            instr_rdata_o  <= '0;
            data_rvalid_o  <= 1'b0;
            data_rdata_o   <= '0;
            err_o          <= 1'b0;

            if (grant) begin
                last_owner_q <= pick;
                owner_q      <= pick;
                wait_cnt_q   <= '0;
                if (pick == DATA) begin
                    mem_addr_o    <= data_addr_i;
                    mem_byte_en_o <= data_byte_en_i;
                    mem_wr_o      <= data_wr_i;
                    mem_wr_data_o <= data_wr_data_i;
                end else begin
                    mem_addr_o    <= instr_addr_i;
                    mem_byte_en_o <= WORD;
                    mem_wr_o      <= 1'b0;
                    mem_wr_data_o <= '0;
                end
            end else if (state_q == BUSY) begin
                if (!mem_ack_i) begin
                    wait_cnt_q <= wait_cnt_q + 1'b1;
                end
                if (ack_done || tmo_done) begin
                    err_o <= tmo_done;
                    if (owner_q == DATA) begin
                        data_rvalid_o <= 1'b1;
                        // Stores and timeouts return zero rather than whatever is on the bus.
                        data_rdata_o  <= (ack_done && !mem_wr_o) ? mem_rd_data_i : '0;
                    end else begin
                        instr_rvalid_o <= 1'b1;
                        instr_rdata_o  <= ack_done ? mem_rd_data_i : '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_yarp_mem_arbiter.sv
// Directed bench for yarp_mem_arbiter with a completion scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_yarp_mem_arbiter;
    import yarp_pkg::*;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i;
    logic [31:0] data_addr_i;
    logic [1:0]  data_byte_en_i;
    logic        data_wr_i;
    logic [31:0] data_wr_data_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        err_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [1:0]  mem_byte_en_o;
    logic        mem_wr_o;
    logic [31:0] mem_wr_data_o;
    logic        mem_ack_i;
    logic [31:0] mem_rd_data_i;

    yarp_mem_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk            (clk),
        .reset          (reset),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .data_req_i     (data_req_i),
        .data_addr_i    (data_addr_i),
        .data_byte_en_i (data_byte_en_i),
        .data_wr_i      (data_wr_i),
        .data_wr_data_i (data_wr_data_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .err_o          (err_o),
        .mem_req_o      (mem_req_o),
        .mem_addr_o     (mem_addr_o),
        .mem_byte_en_o  (mem_byte_en_o),
        .mem_wr_o       (mem_wr_o),
        .mem_wr_data_o  (mem_wr_data_o),
        .mem_ack_i      (mem_ack_i),
        .mem_rd_data_i  (mem_rd_data_i)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          is_data;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Completion monitor: every rvalid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && (instr_rvalid_o || data_rvalid_o)) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rvalid: got instr=%b data=%b want none", instr_rvalid_o, data_rvalid_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("rvalid_port", 32'(data_rvalid_o), 32'(mon_e.is_data));
                check("rvalid_both", 32'(instr_rvalid_o & data_rvalid_o), 32'd0);
                check("rdata", mon_e.is_data ? data_rdata_o : instr_rdata_o, mon_e.rdata);
                check("rdata_other", mon_e.is_data ? instr_rdata_o : data_rdata_o, 32'd0);
                check("err", 32'(err_o), 32'(mon_e.err));
            end
        end
    end

    // Single-requester transaction. Called at posedge+1 of the grant cycle; returns at the
    // negedge of the completion cycle. ack_cyc = 0 means no ack (timeout expected).
    task automatic run_txn(input bit use_data, input logic [31:0] addr, input logic [1:0] be,
                           input bit wr, input logic [31:0] wd, input int ack_cyc,
                           input logic [31:0] rd);
        int last;
        logic [1:0]  exp_be;
        logic [31:0] exp_wd;
        bit          exp_wr;
        last   = (ack_cyc == 0) ? TMO : ack_cyc;
        exp_be = use_data ? be : 2'(WORD);
        exp_wr = use_data ? wr : 1'b0;
        exp_wd = use_data ? wd : 32'd0;
        if (use_data) begin
            data_req_i = 1'b1; data_addr_i = addr; data_byte_en_i = be;
            data_wr_i = wr; data_wr_data_i = wd;
        end else begin
            instr_req_i = 1'b1; instr_addr_i = addr;
        end
        @(negedge clk);
        check("gnt_owner", 32'(use_data ? data_gnt_o : instr_gnt_o), 32'd1);
        check("gnt_other", 32'(use_data ? instr_gnt_o : data_gnt_o), 32'd0);
        exp_q.push_back(exp_t'{use_data, (ack_cyc == 0 || wr) ? 32'd0 : rd, ack_cyc == 0});
        step();
        instr_req_i = 1'b0;
        data_req_i  = 1'b0;
        data_wr_i   = 1'b0;
        for (int c = 1; c <= last; c++) begin
            mem_rd_data_i = rd;
            mem_ack_i     = (c == ack_cyc);
            @(negedge clk);
            check("busy_mem_req", 32'(mem_req_o), 32'd1);
            check("busy_addr", mem_addr_o, addr);
            check("busy_be", 32'(mem_byte_en_o), 32'(exp_be));
            check("busy_wr", 32'(mem_wr_o), 32'(exp_wr));
            check("busy_wdata", mem_wr_data_o, exp_wd);
            check("busy_rvalid", 32'(instr_rvalid_o | data_rvalid_o), 32'd0);
            step();
            mem_ack_i = 1'b0;
        end
        @(negedge clk);
        check("done_rvalid", 32'(use_data ? data_rvalid_o : instr_rvalid_o), 32'd1);
        check("done_mem_req", 32'(mem_req_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        instr_req_i = 1'b1; instr_addr_i = 32'h0;
        data_req_i = 1'b0; data_addr_i = 32'h0; data_byte_en_i = 2'b00;
        data_wr_i = 1'b0; data_wr_data_i = 32'h0;
        mem_ack_i = 1'b0; mem_rd_data_i = 32'h0;
        #2;
        check("rst_instr_gnt", 32'(instr_gnt_o), 32'd0);
        check("rst_mem_req", 32'(mem_req_o), 32'd0);
        check("rst_rvalid", 32'(instr_rvalid_o | data_rvalid_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_mem_addr", mem_addr_o, 32'd0);
        instr_req_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Contention right after reset: data first, then instr, then data again.
        instr_req_i = 1'b1; instr_addr_i = 32'h80;
        data_req_i = 1'b1; data_addr_i = 32'h40; data_byte_en_i = 2'(WORD); data_wr_i = 1'b0;
        @(negedge clk);
        check("cont0_data_gnt", 32'(data_gnt_o), 32'd1);
        check("cont0_instr_gnt", 32'(instr_gnt_o), 32'd0);
        exp_q.push_back(exp_t'{1'b1, 32'h11111111, 1'b0});
        step();
        data_req_i = 1'b0; mem_ack_i = 1'b1; mem_rd_data_i = 32'h11111111;
        @(negedge clk);
        check("cont1_no_gnt_busy", 32'(instr_gnt_o), 32'd0);
        check("cont1_addr", mem_addr_o, 32'h40);
        step();
        mem_ack_i = 1'b0;
        @(negedge clk);
        check("cont2_data_rvalid", 32'(data_rvalid_o), 32'd1);
        check("cont2_instr_gnt", 32'(instr_gnt_o), 32'd1);
        exp_q.push_back(exp_t'{1'b0, 32'h22222222, 1'b0});
        step();
        instr_req_i = 1'b0; mem_ack_i = 1'b1; mem_rd_data_i = 32'h22222222;
        @(negedge clk);
        check("cont3_addr", mem_addr_o, 32'h80);
        check("cont3_be", 32'(mem_byte_en_o), 32'(WORD));
        step();
        mem_ack_i = 1'b0;
        @(negedge clk);
        check("cont4_instr_rvalid", 32'(instr_rvalid_o), 32'd1);
        step();
        instr_req_i = 1'b1; instr_addr_i = 32'h84;
        data_req_i = 1'b1; data_addr_i = 32'h44;
        @(negedge clk);
        check("cont5_data_gnt", 32'(data_gnt_o), 32'd1);
        check("cont5_instr_gnt", 32'(instr_gnt_o), 32'd0);
        exp_q.push_back(exp_t'{1'b1, 32'h33333333, 1'b0});
        step();
        data_req_i = 1'b0; mem_ack_i = 1'b1; mem_rd_data_i = 32'h33333333;
        @(negedge clk);
        check("cont6_addr", mem_addr_o, 32'h44);
        step();
        mem_ack_i = 1'b0;
        @(negedge clk);
        check("cont7_instr_gnt", 32'(instr_gnt_o), 32'd1);
        exp_q.push_back(exp_t'{1'b0, 32'h44444444, 1'b0});
        step();
        instr_req_i = 1'b0; mem_ack_i = 1'b1; mem_rd_data_i = 32'h44444444;
        @(negedge clk);
        check("cont8_addr", mem_addr_o, 32'h84);
        step();
        mem_ack_i = 1'b0;
        @(negedge clk);
        check("cont9_instr_rvalid", 32'(instr_rvalid_o), 32'd1);

        // Single fetch, ack three cycles after grant.
        step();
        run_txn(1'b0, 32'h100, 2'(WORD), 1'b0, 32'h0, 3, 32'hDEADBEEF);

        // Half-word store; bus read data must not leak into rdata.
        step();
        run_txn(1'b1, 32'h2000, 2'(HALF), 1'b1, 32'h1234, 2, 32'hFFFFFFFF);

        // Timeout with no ack.
        step();
        run_txn(1'b1, 32'h3000, 2'(WORD), 1'b0, 32'h0, 0, 32'hCAFEF00D);
        step();
        @(negedge clk);
        check("tmo_after_mem_req", 32'(mem_req_o), 32'd0);
        check("tmo_after_rvalid", 32'(data_rvalid_o), 32'd0);

        // Ack in the very cycle the counter reaches the limit.
        step();
        run_txn(1'b0, 32'h400, 2'(WORD), 1'b0, 32'h0, TMO, 32'h0BADF00D);

        // Ack while idle is ignored.
        step();
        mem_ack_i = 1'b1; mem_rd_data_i = 32'h55555555;
        step();
        mem_ack_i = 1'b0;
        @(negedge clk);
        check("idle_ack_rvalid", 32'(instr_rvalid_o | data_rvalid_o), 32'd0);

        // Reset mid-transaction.
        step();
        data_req_i = 1'b1; data_addr_i = 32'h5000; data_byte_en_i = 2'(WORD); data_wr_i = 1'b0;
        @(negedge clk);
        check("rstm_gnt", 32'(data_gnt_o), 32'd1);
        step();
        data_req_i = 1'b0;
        @(negedge clk);
        check("rstm_busy", 32'(mem_req_o), 32'd1);
        step();
        reset = 1'b1;
        #1;
        check("rstm_mem_req", 32'(mem_req_o), 32'd0);
        check("rstm_rvalid", 32'(instr_rvalid_o | data_rvalid_o), 32'd0);
        mem_ack_i = 1'b1; mem_rd_data_i = 32'h77777777;
        step();
        reset = 1'b0; mem_ack_i = 1'b0;
        @(negedge clk);
        check("rstm_no_rvalid", 32'(instr_rvalid_o | data_rvalid_o), 32'd0);
        step();
        run_txn(1'b0, 32'h600, 2'(WORD), 1'b0, 32'h0, 1, 32'h600DCAFE);

        step();
        step();
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
